// File: rtl/aq_memcpy_pkg.sv
// Shared types and constants for the memcpy write-side engine.
package aq_memcpy_pkg;

  localparam int         BOUNDARY_BYTES = 4096;
  localparam logic [1:0] RESP_OKAY      = 2'b00;
  localparam int         BLEN_WIDTH     = 9;

  typedef enum logic [2:0] {
    IDLE,
    CALC,
    WAIT_DATA,
    ADDR,
    DATA,
    RESP,
    FIN
  } state_t;

endpackage

// File: rtl/aq_memcpy_wr_if.sv
// AXI-style write channel bundle (AW, W, B) between the memcpy engine and memory.
// Handshake rule on every channel: a transfer happens on the rising edge where
// VALID and READY are both high; VALID and its payload hold until that edge.
interface aq_memcpy_wr_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADRS_WIDTH = 32
);
  logic [ADRS_WIDTH-1:0] M_AWADDR;
  logic [7:0]            M_AWLEN;
  logic                  M_AWVALID;
  logic                  M_AWREADY;
  logic [DATA_WIDTH-1:0] M_WDATA;
  logic                  M_WLAST;
  logic                  M_WVALID;
  logic                  M_WREADY;
  logic                  M_BVALID;
  logic [1:0]            M_BRESP;
  logic                  M_BREADY;

  modport master (
    output M_AWADDR, M_AWLEN, M_AWVALID,
    input  M_AWREADY,
    output M_WDATA, M_WLAST, M_WVALID,
    input  M_WREADY,
    input  M_BVALID, M_BRESP,
    output M_BREADY
  );

  modport slave (
    input  M_AWADDR, M_AWLEN, M_AWVALID,
    output M_AWREADY,
    input  M_WDATA, M_WLAST, M_WVALID,
    output M_WREADY,
    output M_BVALID, M_BRESP,
    input  M_BREADY
  );
endinterface

// File: rtl/aq_memcpy_burst_calc.sv
// Burst length = min(remaining words, BURST_MAX, words left before the next 4 KB line).
module aq_memcpy_burst_calc
  import aq_memcpy_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int BURST_MAX  = 16
) (
  input  logic [11:0]           addr_lo,
  input  logic [31:0]           remain,
  output logic [BLEN_WIDTH-1:0] blen
);
  localparam int BYTE_SHIFT = $clog2(DATA_WIDTH / 8);

  logic [12:0] room_bytes;
  logic [12:0] room_words;
  logic [12:0] cap;

  // addr_lo is word aligned, so room_bytes is always a whole number of words
  always_comb begin
    room_bytes = 13'(BOUNDARY_BYTES) - {1'b0, addr_lo};
    room_words = room_bytes >> BYTE_SHIFT;
    cap        = (room_words < 13'(BURST_MAX)) ? room_words : 13'(BURST_MAX);
    if (remain < 32'(cap)) begin
      blen = BLEN_WIDTH'(remain);
    end else begin
      blen = BLEN_WIDTH'(cap);
    end
  end

endmodule

// File: rtl/aq_memcpy_wr.sv
// Drains a show-ahead FIFO into incrementing write bursts, one burst in flight,
// never crossing a 4 KB line; reports completion and sticky response errors.
module aq_memcpy_wr
  import aq_memcpy_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADRS_WIDTH = 32,
  parameter int FIFO_DEPTH = 10,
  parameter int BURST_MAX  = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic [ADRS_WIDTH-1:0] DST_ADRS,
  input  logic [31:0]           LENGTH,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  ERROR,
  output logic                  FIFO_RD_ENA,
  input  logic [DATA_WIDTH-1:0] FIFO_RD_DATA,
  input  logic                  FIFO_RD_EMPTY,
  input  logic                  FIFO_RD_ALM_EMPTY,
  output logic [FIFO_DEPTH-1:0] FIFO_RD_ALM_COUNT,
  aq_memcpy_wr_if.master        m_axi,
  output state_t                DBG_STATE
);
  localparam int BYTES      = DATA_WIDTH / 8;
  localparam int BYTE_SHIFT = $clog2(BYTES);
  localparam logic [BLEN_WIDTH-1:0] BLEN_ONE = BLEN_WIDTH'(1);

  state_t                state, state_nxt;
  logic [ADRS_WIDTH-1:0] addr;
  logic [31:0]           remain;
  logic [BLEN_WIDTH-1:0] blen, blen_calc, beat;
  logic [FIFO_DEPTH-1:0] alm_count;
  logic                  wait_first;
  logic                  busy_q, done_q, error_q;
  logic                  start_acc, w_valid, w_last, w_hs, last_burst;

  aq_memcpy_burst_calc #(
    .DATA_WIDTH (DATA_WIDTH),
    .BURST_MAX  (BURST_MAX)
  ) u_burst_calc (
    .addr_lo (addr[11:0]),
    .remain  (remain),
    .blen    (blen_calc)
  );

  always_comb begin
    state_nxt  = state;
    start_acc  = 1'b0;
    w_valid    = 1'b0;
    w_last     = 1'b0;
    w_hs       = 1'b0;
    last_burst = (remain == 32'(blen));
    case (state)
      // a START coinciding with the DONE pulse belongs to the finished transfer
      IDLE: begin
        if (START && !done_q) begin
          start_acc = 1'b1;
          state_nxt = (LENGTH == '0) ? FIN : CALC;
        end
      end
      CALC: state_nxt = WAIT_DATA;
      // first cycle lets the FIFO re-evaluate ALM_EMPTY against the new threshold
      WAIT_DATA: begin
        if (!wait_first && !FIFO_RD_ALM_EMPTY && !FIFO_RD_EMPTY) state_nxt = ADDR;
      end
      ADDR: if (m_axi.M_AWREADY) state_nxt = DATA;
      DATA: begin
        w_valid = !FIFO_RD_EMPTY;
        w_last  = (beat == blen - BLEN_ONE);
        w_hs    = w_valid && m_axi.M_WREADY;
        if (w_hs && w_last) state_nxt = RESP;
      end
      RESP: if (m_axi.M_BVALID) state_nxt = last_burst ? FIN : CALC;
      FIN:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      addr       <= '0;
      remain     <= '0;
      blen       <= '0;
      beat       <= '0;
      alm_count  <= '0;
      wait_first <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= (state == FIN);
      case (state)
        IDLE: begin
          if (start_acc) begin
            addr    <= DST_ADRS & ~ADRS_WIDTH'(BYTES - 1);
            remain  <= LENGTH;
            error_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        CALC: begin
          blen       <= blen_calc;
          alm_count  <= FIFO_DEPTH'(blen_calc - BLEN_ONE);
          beat       <= '0;
          wait_first <= 1'b1;
        end
        WAIT_DATA: wait_first <= 1'b0;
        DATA: begin
          if (w_hs) beat <= w_last ? '0 : beat + BLEN_ONE;
        end
        RESP: begin
          if (m_axi.M_BVALID) begin
            error_q <= error_q | (m_axi.M_BRESP != RESP_OKAY);
            remain  <= remain - 32'(blen);
            addr    <= addr + (ADRS_WIDTH'(blen) << BYTE_SHIFT);
          end
        end
        FIN: busy_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign m_axi.M_AWVALID = (state == ADDR);
  assign m_axi.M_AWADDR  = addr;
  assign m_axi.M_AWLEN   = (state == ADDR) ? 8'(blen - BLEN_ONE) : 8'd0;
  assign m_axi.M_WVALID  = w_valid;
  assign m_axi.M_WLAST   = w_last;
  assign m_axi.M_WDATA   = (state == DATA) ? FIFO_RD_DATA : '0;
  assign m_axi.M_BREADY  = (state == RESP);

  assign FIFO_RD_ENA       = w_hs;
  assign FIFO_RD_ALM_COUNT = alm_count;
  assign BUSY              = busy_q;
  assign DONE              = done_q;
  assign ERROR             = error_q;
  assign DBG_STATE         = state;

endmodule

// File: tb/tb_aq_memcpy_wr.sv
// Directed bench for aq_memcpy_wr: FIFO and memory models drive at negedge,
// everything is sampled 1 ns later so handshakes are judged away from posedge.
module tb_aq_memcpy_wr;
  import aq_memcpy_pkg::*;

  localparam int DW = 64;
  localparam int AW = 32;
  localparam int FD = 10;
  localparam int BM = 16;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          start;
  logic [AW-1:0] dst_adrs;
  logic [31:0]   length;
  logic          busy, done, error;
  logic          fifo_rd_ena;
  logic [DW-1:0] fifo_rd_data;
  logic          fifo_rd_empty, fifo_rd_alm_empty;
  logic [FD-1:0] fifo_rd_alm_count;
  state_t        dbg_state;

  aq_memcpy_wr_if #(.DATA_WIDTH(DW), .ADRS_WIDTH(AW)) m_axi ();

  aq_memcpy_wr #(
    .DATA_WIDTH (DW),
    .ADRS_WIDTH (AW),
    .FIFO_DEPTH (FD),
    .BURST_MAX  (BM)
  ) dut (
    .CLK               (clk),
    .RST               (rst),
    .START             (start),
    .DST_ADRS          (dst_adrs),
    .LENGTH            (length),
    .BUSY              (busy),
    .DONE              (done),
    .ERROR             (error),
    .FIFO_RD_ENA       (fifo_rd_ena),
    .FIFO_RD_DATA      (fifo_rd_data),
    .FIFO_RD_EMPTY     (fifo_rd_empty),
    .FIFO_RD_ALM_EMPTY (fifo_rd_alm_empty),
    .FIFO_RD_ALM_COUNT (fifo_rd_alm_count),
    .m_axi             (m_axi),
    .DBG_STATE         (dbg_state)
  );

  // scoreboard
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  logic [AW-1:0] aw_addr_log[$];
  logic [7:0]    aw_len_log[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // environment state shared by the bus model and the directed sequence
  int cyc = 0;
  int pops, busy_cnt, done_cnt, done_cyc, last_b_cyc, b_cnt, b_idx, err_rise_b;
  int overlap, order_err, ena_err, beat_cnt, cur_len, b_wait;
  int bresp_tab[4];
  bit pop_pend, b_hs, aw_open, err_prev;
  bit aw_rand, w_rand, w_hold;

  // memory slave + FIFO model + monitor
  always @(negedge clk) begin
    if (rst) begin
      pop_pend = 1'b0; b_hs = 1'b0; b_wait = 0; aw_open = 1'b0; beat_cnt = 0; err_prev = 1'b0;
      m_axi.M_BVALID = 1'b0;
      m_axi.M_BRESP  = 2'b00;
    end
    if (pop_pend) begin
      if (fifo_q.size() > 0) void'(fifo_q.pop_front());
      pop_pend = 1'b0;
    end
    if (b_hs) begin
      m_axi.M_BVALID = 1'b0;
      m_axi.M_BRESP  = 2'b00;
      b_hs = 1'b0;
      b_idx++;
    end
    if (b_wait > 0) begin
      b_wait--;
      if (b_wait == 0) begin
        m_axi.M_BVALID = 1'b1;
        m_axi.M_BRESP  = 2'(bresp_tab[b_idx % 4]);
      end
    end
    m_axi.M_AWREADY = aw_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    m_axi.M_WREADY  = w_hold ? 1'b0 : (w_rand ? 1'($urandom_range(0, 1)) : 1'b1);
    fifo_rd_empty     = (fifo_q.size() == 0);
    fifo_rd_data      = fifo_rd_empty ? '0 : fifo_q[0];
    fifo_rd_alm_empty = fifo_rd_empty ? 1'b1 : ((fifo_q.size() - 1) < int'(fifo_rd_alm_count));
    #1;
    cyc++;
    if (busy) busy_cnt++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (error && !err_prev) err_rise_b = b_cnt;
    err_prev = error;
    if (m_axi.M_AWVALID && (m_axi.M_WVALID || aw_open)) overlap++;
    if (fifo_rd_ena !== (m_axi.M_WVALID && m_axi.M_WREADY)) ena_err++;
    if (fifo_rd_ena) begin
      pop_pend = 1'b1;
      pops++;
    end
    if (m_axi.M_WVALID && !aw_open) order_err++;
    if (m_axi.M_WVALID && m_axi.M_WREADY) begin
      if (exp_q.size() > 0) check("wdata", m_axi.M_WDATA, exp_q.pop_front());
      else                  check("wdata_extra", 64'd1, 64'd0);
      check("wlast", 64'(m_axi.M_WLAST), 64'(beat_cnt == cur_len));
      beat_cnt++;
      if (m_axi.M_WLAST) begin
        aw_open = 1'b0;
        b_wait  = 2;
      end
    end
    if (m_axi.M_AWVALID && m_axi.M_AWREADY) begin
      aw_addr_log.push_back(m_axi.M_AWADDR);
      aw_len_log.push_back(m_axi.M_AWLEN);
      cur_len  = int'(m_axi.M_AWLEN);
      aw_open  = 1'b1;
      beat_cnt = 0;
    end
    if (m_axi.M_BVALID && m_axi.M_BREADY) begin
      b_hs = 1'b1;
      b_cnt++;
      last_b_cyc = cyc;
    end
  end

  // driver tasks
  task automatic clear_logs();
    aw_addr_log.delete();
    aw_len_log.delete();
    pops = 0; busy_cnt = 0; done_cnt = 0; done_cyc = -1; last_b_cyc = -1;
    b_cnt = 0; b_idx = 0; err_rise_b = -1; overlap = 0; order_err = 0; ena_err = 0;
  endtask

  task automatic push_words(input int n, input logic [DW-1:0] base);
    for (int i = 0; i < n; i++) begin
      fifo_q.push_back(base + DW'(i));
      exp_q.push_back(base + DW'(i));
    end
  endtask

  task automatic start_xfer(input logic [AW-1:0] a, input int len);
    @(negedge clk);
    start = 1'b1; dst_adrs = a; length = 32'(len);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(negedge clk); #2;
      n++;
    end
    check({tag, "_done_seen"}, 64'(done_cnt != 0), 64'd1);
    repeat (3) @(negedge clk);
    #2;
  endtask

  task automatic check_bursts(input string tag, input int nb,
                              input logic [AW-1:0] a0, input int l0,
                              input logic [AW-1:0] a1, input int l1,
                              input logic [AW-1:0] a2, input int l2);
    logic [AW-1:0] ea[3];
    int            el[3];
    ea = '{a0, a1, a2};
    el = '{l0, l1, l2};
    check({tag, "_aw_cnt"}, 64'(aw_addr_log.size()), 64'(nb));
    for (int i = 0; i < nb && i < aw_addr_log.size(); i++) begin
      check({tag, "_awaddr"}, 64'(aw_addr_log[i]), 64'(ea[i]));
      check({tag, "_awlen"},  64'(aw_len_log[i]),  64'(el[i]));
    end
  endtask

  task automatic check_clean(input string tag, input int exp_pops);
    check({tag, "_pops"},      64'(pops),         64'(exp_pops));
    check({tag, "_exp_left"},  64'(exp_q.size()), 64'd0);
    check({tag, "_overlap"},   64'(overlap),      64'd0);
    check({tag, "_w_order"},   64'(order_err),    64'd0);
    check({tag, "_rd_ena"},    64'(ena_err),      64'd0);
    check({tag, "_done_cnt"},  64'(done_cnt),     64'd1);
    check({tag, "_busy_end"},  64'(busy),         64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, 64'({busy, done, error, fifo_rd_ena, m_axi.M_AWVALID,
                              m_axi.M_WVALID, m_axi.M_WLAST, m_axi.M_BREADY}), 64'd0);
    check({tag, "_awaddr"}, 64'(m_axi.M_AWADDR), 64'd0);
    check({tag, "_awlen"},  64'(m_axi.M_AWLEN),  64'd0);
    check({tag, "_wdata"},  m_axi.M_WDATA,       64'd0);
    check({tag, "_almcnt"}, 64'(fifo_rd_alm_count), 64'd0);
    check({tag, "_state"},  64'(dbg_state),      64'(IDLE));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int n;
    rst = 1'b1; start = 1'b0; dst_adrs = '0; length = '0;
    aw_rand = 1'b0; w_rand = 1'b0; w_hold = 1'b0;
    bresp_tab = '{0, 0, 0, 0};
    m_axi.M_AWREADY = 1'b0; m_axi.M_WREADY = 1'b0;
    m_axi.M_BVALID = 1'b0;  m_axi.M_BRESP = 2'b00;
    clear_logs();
    repeat (3) @(negedge clk);
    #2 check_all_zero("reset");
    @(negedge clk); rst = 1'b0;

    // T1: zero length, START during DONE ignored, START one cycle later accepted
    clear_logs();
    @(negedge clk);
    start = 1'b1; dst_adrs = 32'h0; length = 32'd0;
    #2 t0 = cyc;
    @(negedge clk); start = 1'b0;
    @(negedge clk); start = 1'b1;
    #2 check("t1_done_at_plus2", 64'(done), 64'd1);
    @(negedge clk);
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    #2;
    check("t1_done_cnt",  64'(done_cnt), 64'd2);
    check("t1_done_cyc",  64'(done_cyc), 64'(t0 + 5));
    check("t1_busy_cnt",  64'(busy_cnt), 64'd2);
    check("t1_no_aw",     64'(aw_addr_log.size()), 64'd0);
    check("t1_no_w",      64'(pops), 64'd0);

    // T2: 40 words from 0x1000, random AWREADY, START while busy ignored
    clear_logs();
    aw_rand = 1'b1;
    push_words(40, 64'hA5A5_0000_0000_0000);
    start_xfer(32'h1000, 40);
    @(negedge clk); start = 1'b1; dst_adrs = 32'h5000; length = 32'd1;
    @(negedge clk); start = 1'b0;
    wait_done("t2", 2000);
    check_bursts("t2", 3, 32'h1000, 15, 32'h1080, 15, 32'h1100, 7);
    check_clean("t2", 40);
    check("t2_done_after_b", 64'(done_cyc - last_b_cyc), 64'd2);
    check("t2_error", 64'(error), 64'd0);
    aw_rand = 1'b0;

    // T3: 4 KB line split, unaligned low address bits dropped
    clear_logs();
    push_words(10, 64'h3333_0000_0000_0100);
    start_xfer(32'h0FE5, 10);
    wait_done("t3", 1000);
    check_bursts("t3", 2, 32'h0FE0, 3, 32'h1000, 5, 32'h0, 0);
    check_clean("t3", 10);

    // T4: no address phase until a full burst is in the FIFO
    clear_logs();
    push_words(3, 64'h4444_0000_0000_0200);
    start_xfer(32'h2000, 8);
    repeat (30) @(negedge clk);
    #2;
    check("t4_no_aw_early", 64'(aw_addr_log.size()), 64'd0);
    check("t4_no_pop_early", 64'(pops), 64'd0);
    check("t4_busy_wait", 64'(busy), 64'd1);
    push_words(5, 64'h4444_0000_0000_0203);
    wait_done("t4", 1000);
    check_bursts("t4", 1, 32'h2000, 7, 32'h0, 0, 32'h0, 0);
    check_clean("t4", 8);

    // T5: WREADY toggling
    clear_logs();
    w_rand = 1'b1;
    push_words(8, 64'h5555_0000_0000_0300);
    start_xfer(32'h3000, 8);
    wait_done("t5", 1000);
    check_bursts("t5", 1, 32'h3000, 7, 32'h0, 0, 32'h0, 0);
    check_clean("t5", 8);
    w_rand = 1'b0;

    // T6: SLVERR on burst 2 of 3
    clear_logs();
    bresp_tab = '{0, 2, 0, 0};
    push_words(40, 64'h6666_0000_0000_0400);
    start_xfer(32'h4000, 40);
    wait_done("t6", 2000);
    check_bursts("t6", 3, 32'h4000, 15, 32'h4080, 15, 32'h4100, 7);
    check_clean("t6", 40);
    check("t6_err_rise_at_b2", 64'(err_rise_b), 64'd2);
    check("t6_err_held", 64'(error), 64'd1);
    bresp_tab = '{0, 0, 0, 0};
    clear_logs();
    start_xfer(32'h5000, 0);
    #2 check("t6_err_cleared", 64'(error), 64'd0);
    wait_done("t6b", 50);

    // T7: reset while stalled in the data phase
    clear_logs();
    w_hold = 1'b1;
    push_words(16, 64'h7777_0000_0000_0500);
    start_xfer(32'h6000, 16);
    n = 0;
    while (dbg_state != DATA && n < 200) begin
      @(negedge clk); #2;
      n++;
    end
    check("t7_reached_data", 64'(dbg_state), 64'(DATA));
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    #2 check_all_zero("t7_rst");
    rst = 1'b0;
    fifo_q.delete();
    exp_q.delete();
    w_hold = 1'b0;
    repeat (2) @(negedge clk);
    clear_logs();
    push_words(4, 64'h8888_0000_0000_0600);
    start_xfer(32'h7000, 4);
    wait_done("t7_recover", 500);
    check_bursts("t7_recover", 1, 32'h7000, 3, 32'h0, 0, 32'h0, 0);
    check_clean("t7_recover", 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aq_memcpy_wr.md
Name: aq_memcpy_wr

Overview:
Write-side engine of the memcpy datapath. It drains the read port of the clock-domain-crossing FIFO (show-ahead read interface) and issues AXI-style incrementing write bursts to memory. Software programs a destination address and a word count. The block splits the transfer into bursts that respect BURST_MAX and 4 KB boundaries. It reports completion and any write-response error.

Parameters:
DATA_WIDTH, 64, word width in bits (power of two, 32..512); BYTES = DATA_WIDTH/8
ADRS_WIDTH, 32, memory address width
FIFO_DEPTH, 10, log2 of the attached FIFO depth; width of FIFO_RD_ALM_COUNT
BURST_MAX, 16, maximum beats per burst (1..256, at most 2**FIFO_DEPTH)

Ports:
CLK  in  1  single clock; also drives the attached FIFO read clock
RST  in  1  synchronous reset, active-high
START  in  1  one-cycle request to begin a transfer; ignored while BUSY=1
DST_ADRS  in  ADRS_WIDTH  destination byte address; low log2(BYTES) bits treated as 0
LENGTH  in  32  transfer length in words
BUSY  out  1  high from the cycle after an accepted START until DONE
DONE  out  1  one-cycle pulse at end of transfer
ERROR  out  1  sticky; set on any non-zero BRESP; cleared by the next accepted START
FIFO_RD_ENA  out  1  pop strobe
FIFO_RD_DATA  in  DATA_WIDTH  head word; valid when FIFO_RD_EMPTY=0
FIFO_RD_EMPTY  in  1  FIFO has no valid head word
FIFO_RD_ALM_EMPTY  in  1  high when the FIFO internal count (excluding the head word) is below FIFO_RD_ALM_COUNT
FIFO_RD_ALM_COUNT  out  FIFO_DEPTH  almost-empty threshold
M_AWADDR  out  ADRS_WIDTH  burst address
M_AWLEN  out  8  beats-1
M_AWVALID  out  1  address valid
M_AWREADY  in  1  address ready
M_WDATA  out  DATA_WIDTH  write data, driven combinationally from FIFO_RD_DATA
M_WLAST  out  1  last beat of the burst
M_WVALID  out  1  data valid
M_WREADY  in  1  data ready
M_BVALID  in  1  response valid
M_BRESP  in  2  response code; 0 = OKAY
M_BREADY  out  1  response ready

Behaviour:
- Reset values: all outputs 0, except FIFO_RD_ALM_COUNT=0. FSM returns to IDLE. Any in-flight burst is abandoned with no completion. FIFO contents are not touched; the system resets the FIFO together with this block.
- FSM states: IDLE, CALC, WAIT_DATA, ADDR, DATA, RESP, FIN.
- IDLE: on START, latch addr=DST_ADRS (aligned) and remain=LENGTH, clear ERROR, set BUSY.
  - LENGTH=0 -> FIN.
  - Otherwise -> CALC.
- CALC, 1 cycle: blen = min(remain, BURST_MAX, (4096 - addr[11:0])/BYTES). Register blen (9 bits) and set FIFO_RD_ALM_COUNT = blen-1. -> WAIT_DATA.
- WAIT_DATA: the first cycle is a settle cycle and flags are ignored. From the second cycle, if FIFO_RD_ALM_EMPTY=0 and FIFO_RD_EMPTY=0, at least blen words are available. -> ADDR. No timeout.
- ADDR: M_AWVALID=1, M_AWADDR=addr, M_AWLEN=blen-1. AWVALID is held until M_AWREADY, and the address/length stay stable while waiting. -> DATA.
- DATA:
  - M_WVALID = ~FIFO_RD_EMPTY.
  - FIFO_RD_ENA = M_WVALID & M_WREADY, so a pop happens only on a handshake.
  - M_WLAST = (beat == blen-1).
  - beat increments on each handshake. A handshake with WLAST -> RESP.
  - FIFO underflow during DATA only stalls the beat; it is never an error.
- RESP: M_BREADY=1. On M_BVALID, ERROR |= (M_BRESP != 0); remain -= blen; addr += blen*BYTES.
  - remain==0 -> FIN.
  - Otherwise -> CALC.
- FIN: DONE=1 for one cycle, BUSY=0. -> IDLE.
- Only one burst is outstanding at a time. AW and W never overlap, and W follows the AW handshake.
- Address arithmetic wraps modulo 2**ADRS_WIDTH. No burst ever crosses a 4 KB boundary.
- START while BUSY=1 has no effect. START in the same cycle as DONE is ignored. START in the cycle after DONE is accepted.

Decomposition:
- Package aq_memcpy_pkg holds:
  - the state enum;
  - BOUNDARY_BYTES=4096;
  - RESP_OKAY=2'b00;
  - the blen width constant (9).
- One sub-module, aq_memcpy_burst_calc, computes blen from addr, remain and BURST_MAX. It is registered in CALC.

Test Plan:
1. LENGTH=0, START -> DONE pulse 2 cycles later, no AWVALID/WVALID, BUSY high for exactly 1 cycle.
2. DST_ADRS=0x1000, LENGTH=40, FIFO prefilled with 40 words -> 3 bursts: 0x1000 AWLEN=15, 0x1080 AWLEN=15, 0x1100 AWLEN=7; data in FIFO order; DONE 2 cycles after the last BVALID.
3. DST_ADRS=0x0FE0, LENGTH=10 -> bursts 0x0FE0 AWLEN=3 and 0x1000 AWLEN=5; none crosses 0x1000.
4. FIFO holds 3 words, LENGTH=8 -> no AWVALID until the 8th word has been written; AWLEN=7 once available.
5. M_WREADY toggling pseudo-randomly, LENGTH=8 -> exactly 8 pops, no duplicated or dropped words, WLAST only on beat 8.
6. BRESP=2 on burst 2 of 3 -> ERROR set and held, transfer completes, DONE pulses, ERROR clears on the next START. Separately, RST asserted mid-DATA -> all outputs 0 on the next cycle, FSM in IDLE.
